// File: rtl/pool_window_buffer_pkg.sv
// Shared constants for the pooling front-end: pixel width and default
// feature-map dimensions before and after 2x2 pooling.
package pool_window_buffer_pkg;
  localparam int DATA_W = 8;
  localparam int MAP_W  = 24;
  localparam int MAP_H  = 24;
  localparam int POOL_W = MAP_W / 2;
  localparam int POOL_H = MAP_H / 2;

  // Index width that never collapses to zero bits for tiny dimensions.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pool_window_buffer_line_buffer.sv
// One-row pixel store: single write port, independent combinational read.
// Kept as its own module so a BRAM can replace it for wide feature maps.
module line_buffer #(
  parameter int DATA_W = pool_window_buffer_pkg::DATA_W,
  parameter int DEPTH  = pool_window_buffer_pkg::MAP_W,
  parameter int AW     = pool_window_buffer_pkg::clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pool_window_buffer.sv
// Streaming 2x2 non-overlapping window generator feeding the average-pool stage.
// Even rows fill the line buffer; odd rows at odd columns emit a registered window.
module pool_window_buffer #(
  parameter int  DATA_W = pool_window_buffer_pkg::DATA_W,
  parameter int  IMG_W  = pool_window_buffer_pkg::MAP_W,
  parameter int  IMG_H  = pool_window_buffer_pkg::MAP_H,
  localparam int XW     = pool_window_buffer_pkg::clog2_min1(IMG_W / 2),
  localparam int YW     = pool_window_buffer_pkg::clog2_min1(IMG_H / 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              win_valid,
  output logic [DATA_W-1:0] win_tl,
  output logic [DATA_W-1:0] win_tr,
  output logic [DATA_W-1:0] win_bl,
  output logic [DATA_W-1:0] win_br,
  output logic [XW-1:0]     win_col,
  output logic [YW-1:0]     win_row,
  output logic              frame_done
);
  import pool_window_buffer_pkg::*;

  localparam int CW = clog2_min1(IMG_W);
  localparam int RW = clog2_min1(IMG_H);

  logic [CW-1:0]     col, col_eff, col_nxt;
  logic [RW-1:0]     row, row_eff, row_nxt;
  logic [DATA_W-1:0] prev_pix, tl_hold, lb_rdata;
  logic              last_col, last_row, emit, lb_we;

  // A start-of-frame pixel is always (0,0), so it can never emit a window.
  always_comb begin
    col_eff  = in_sof ? '0 : col;
    row_eff  = in_sof ? '0 : row;
    last_col = (col_eff == CW'(IMG_W - 1));
    last_row = (row_eff == RW'(IMG_H - 1));
    col_nxt  = last_col ? '0 : col_eff + CW'(1);
    row_nxt  = row_eff;
    if (last_col) row_nxt = last_row ? '0 : row_eff + RW'(1);
    emit     = in_valid && row_eff[0] && col_eff[0];
    lb_we    = in_valid && !row_eff[0];
  end

  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (col_eff),
    .wdata (in_pixel),
    .raddr (col_eff),
    .rdata (lb_rdata)
  );

  // tl_hold latches linebuf[col-1] at the even column of an odd row, so the
  // single read port only has to supply linebuf[col] at emission time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      prev_pix   <= '0;
      tl_hold    <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_tl     <= '0;
      win_tr     <= '0;
      win_bl     <= '0;
      win_br     <= '0;
      win_col    <= '0;
      win_row    <= '0;
    end else begin
      win_valid  <= emit;
      frame_done <= emit && last_row && last_col;
      if (in_valid) begin
        col      <= col_nxt;
        row      <= row_nxt;
        prev_pix <= in_pixel;
        if (row_eff[0] && !col_eff[0]) tl_hold <= lb_rdata;
      end
      if (emit) begin
        win_tl  <= tl_hold;
        win_tr  <= lb_rdata;
        win_bl  <= prev_pix;
        win_br  <= in_pixel;
        win_col <= XW'(col_eff >> 1);
        win_row <= YW'(row_eff >> 1);
      end
    end
  end
endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer: a 4x4 and a 24x24 instance driven with frames
// and checked against a frame-array model of the 2x2 block decomposition.
module tb_pool_window_buffer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v4, s4, v24, s24;
  logic [7:0] p4, p24;
  logic       wv4, fd4, wv24, fd24;
  logic [7:0] tl4, tr4, bl4, br4, tl24, tr24, bl24, br24;
  logic [0:0] wc4, wr4;
  logic [3:0] wc24, wr24;

  pool_window_buffer #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_sof(s4), .in_pixel(p4),
    .win_valid(wv4), .win_tl(tl4), .win_tr(tr4), .win_bl(bl4), .win_br(br4),
    .win_col(wc4), .win_row(wr4), .frame_done(fd4));

  pool_window_buffer #(.DATA_W(8), .IMG_W(24), .IMG_H(24)) dut24 (
    .clk(clk), .rst(rst), .in_valid(v24), .in_sof(s24), .in_pixel(p24),
    .win_valid(wv24), .win_tl(tl24), .win_tr(tr24), .win_bl(bl24), .win_br(br24),
    .win_col(wc24), .win_row(wr24), .frame_done(fd24));

  typedef struct {
    logic [7:0] tl, tr, bl, br;
    int         col, row;
    logic       done;
    int         cyc;
    int         avg;
  } win_t;

  win_t       obs4[$], obs24[$], expq[$];
  logic [7:0] frame [0:23][0:23];
  int         mr = 0, mc = 0;
  int         cyc = 0;
  int         stray_fd = 0;
  int         n_checks = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    win_t w;
    if (wv4 === 1'b1) begin
      w.tl = tl4; w.tr = tr4; w.bl = bl4; w.br = br4;
      w.col = int'(wc4); w.row = int'(wr4); w.done = fd4; w.cyc = cyc; w.avg = 0;
      obs4.push_back(w);
    end
    if (wv24 === 1'b1) begin
      w.tl = tl24; w.tr = tr24; w.bl = bl24; w.br = br24;
      w.col = int'(wc24); w.row = int'(wr24); w.done = fd24; w.cyc = cyc; w.avg = 0;
      obs24.push_back(w);
    end
    if ((fd4 === 1'b1 && wv4 !== 1'b1) || (fd24 === 1'b1 && wv24 !== 1'b1))
      stray_fd++;
  end

  // Model: place each pixel in a frame array; every completed 2x2 block is a window.
  task automatic model_pixel(input int w, input int h, input bit sof,
                             input logic [7:0] pix, input int tag);
    win_t e;
    if (sof) begin mr = 0; mc = 0; end
    frame[mr][mc] = pix;
    if (mr % 2 == 1 && mc % 2 == 1) begin
      e.tl = frame[mr-1][mc-1]; e.tr = frame[mr-1][mc];
      e.bl = frame[mr][mc-1];   e.br = pix;
      e.col = mc / 2; e.row = mr / 2;
      e.done = (mr == h - 1 && mc == w - 1);
      e.cyc = tag + 1;
      e.avg = (int'(e.tl) + int'(e.tr) + int'(e.bl) + int'(e.br)) / 4;
      expq.push_back(e);
    end
    mc++;
    if (mc == w) begin
      mc = 0; mr++;
      if (mr == h) mr = 0;
    end
  endtask

  task automatic drive(input bit big, input bit v, input bit sof, input logic [7:0] pix);
    @(negedge clk);
    if (big) begin v24 = v; s24 = sof; p24 = pix; v4 = 1'b0; end
    else     begin v4 = v;  s4 = sof;  p4 = pix;  v24 = 1'b0; end
    if (v) model_pixel(big ? 24 : 4, big ? 24 : 4, sof, pix, cyc);
  endtask

  // Idle cycles carry random sof/pixel values with valid low; they must be ignored.
  task automatic idle(input bit big, input int n);
    for (int i = 0; i < n; i++) drive(big, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic clear_queues();
    expq.delete(); obs4.delete(); obs24.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; v4 = 0; s4 = 0; p4 = 0; v24 = 0; s24 = 0; p24 = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wv4, fd4, tl4, tr4, bl4, br4, wc4, wr4} !== '0)
      $display("FAIL reset_out4 got %h required 0", {wv4, fd4, tl4, tr4, bl4, br4, wc4, wr4});
    else n_pass++;
    n_checks++;
    if ({wv24, fd24, tl24, tr24, bl24, br24, wc24, wr24} !== '0)
      $display("FAIL reset_out24 got %h required 0", {wv24, fd24, tl24, tr24, bl24, br24, wc24, wr24});
    else n_pass++;
    rst = 1'b0;
    mr = 0; mc = 0;
  endtask

  task automatic test_ramp(input bit gaps);
    clear_queues();
    for (int p = 0; p < 16; p++) begin
      drive(1'b0, 1'b1, p == 0, 8'(4 * (p / 4) + (p % 4)));
      if (gaps) idle(1'b0, $urandom_range(0, 2));
    end
    idle(1'b0, 3);
    n_checks++;
    if (obs4.size() !== 4) $display("FAIL ramp_count gaps=%0d got %0d required 4", gaps, obs4.size());
    else n_pass++;
    for (int i = 0; i < obs4.size() && i < expq.size(); i++) begin
      int t;
      t = (i / 2) * 8 + (i % 2) * 2;
      n_checks++;
      if ({obs4[i].tl, obs4[i].tr, obs4[i].bl, obs4[i].br, obs4[i].col, obs4[i].row, obs4[i].done}
          !== {8'(t), 8'(t + 1), 8'(t + 4), 8'(t + 5), i % 2, i / 2, i == 3})
        $display("FAIL ramp_win gaps=%0d #%0d got %h,%h,%h,%h @(%0d,%0d) done=%0d required %h,%h,%h,%h @(%0d,%0d) done=%0d",
                 gaps, i, obs4[i].tl, obs4[i].tr, obs4[i].bl, obs4[i].br, obs4[i].col, obs4[i].row,
                 obs4[i].done, 8'(t), 8'(t + 1), 8'(t + 4), 8'(t + 5), i % 2, i / 2, i == 3);
      else n_pass++;
      n_checks++;
      if (obs4[i].cyc !== expq[i].cyc)
        $display("FAIL ramp_latency gaps=%0d #%0d got cycle %0d required %0d", gaps, i, obs4[i].cyc, expq[i].cyc);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int ff_cnt = 0, done_cnt = 0;
    clear_queues();
    for (int p = 0; p < 6; p++) drive(1'b0, 1'b1, p == 0, 8'($urandom_range(0, 254)));
    for (int p = 0; p < 16; p++) drive(1'b0, 1'b1, p == 0, 8'hFF);
    idle(1'b0, 3);
    n_checks++;
    if (obs4.size() !== expq.size())
      $display("FAIL abort_count got %0d required %0d", obs4.size(), expq.size());
    else n_pass++;
    for (int i = 0; i < obs4.size() && i < expq.size(); i++) begin
      n_checks++;
      if ({obs4[i].tl, obs4[i].tr, obs4[i].bl, obs4[i].br, obs4[i].col, obs4[i].row, obs4[i].done, obs4[i].cyc}
          !== {expq[i].tl, expq[i].tr, expq[i].bl, expq[i].br, expq[i].col, expq[i].row, expq[i].done, expq[i].cyc})
        $display("FAIL abort_win #%0d got %h,%h,%h,%h @(%0d,%0d) required %h,%h,%h,%h @(%0d,%0d)",
                 i, obs4[i].tl, obs4[i].tr, obs4[i].bl, obs4[i].br, obs4[i].col, obs4[i].row,
                 expq[i].tl, expq[i].tr, expq[i].bl, expq[i].br, expq[i].col, expq[i].row);
      else n_pass++;
    end
    foreach (obs4[i]) begin
      if ({obs4[i].tl, obs4[i].tr, obs4[i].bl, obs4[i].br} === 32'hFFFF_FFFF) ff_cnt++;
      if (obs4[i].done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (ff_cnt !== 4 || done_cnt !== 1)
      $display("FAIL abort_ff got %0d FF windows, %0d frame_done required 4, 1", ff_cnt, done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    win_t last;
    clear_queues();
    for (int p = 0; p < 9; p++) drive(1'b0, 1'b1, p == 0, 8'($urandom_range(1, 255)));
    @(negedge clk);
    v4 = 1'b1; s4 = 1'b0; p4 = 8'($urandom);
    last = expq[expq.size() - 1];
    n_checks++;
    if ({tl4, tr4, bl4, br4} !== {last.tl, last.tr, last.bl, last.br})
      $display("FAIL pre_reset_hold got %h required %h", {tl4, tr4, bl4, br4}, {last.tl, last.tr, last.bl, last.br});
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({wv4, fd4, tl4, tr4, bl4, br4, wc4, wr4} !== '0)
      $display("FAIL midframe_reset got %h required 0", {wv4, fd4, tl4, tr4, bl4, br4, wc4, wr4});
    else n_pass++;
    @(negedge clk);
    v4 = 1'b0; rst = 1'b0;
    mr = 0; mc = 0;
    clear_queues();
    for (int p = 0; p < 16; p++) drive(1'b0, 1'b1, 1'b0, 8'($urandom));
    idle(1'b0, 3);
    n_checks++;
    if (obs4.size() !== 4) $display("FAIL post_reset_count got %0d required 4", obs4.size());
    else n_pass++;
    for (int i = 0; i < obs4.size() && i < expq.size(); i++) begin
      n_checks++;
      if ({obs4[i].tl, obs4[i].tr, obs4[i].bl, obs4[i].br, obs4[i].col, obs4[i].row, obs4[i].done, obs4[i].cyc}
          !== {expq[i].tl, expq[i].tr, expq[i].bl, expq[i].br, expq[i].col, expq[i].row, expq[i].done, expq[i].cyc})
        $display("FAIL post_reset_win #%0d got %h,%h,%h,%h @(%0d,%0d) required %h,%h,%h,%h @(%0d,%0d)",
                 i, obs4[i].tl, obs4[i].tr, obs4[i].bl, obs4[i].br, obs4[i].col, obs4[i].row,
                 expq[i].tl, expq[i].tr, expq[i].bl, expq[i].br, expq[i].col, expq[i].row);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0, avg_errs = 0, done_cnt = 0;
    clear_queues();
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 576; p++) drive(1'b1, 1'b1, p == 0, 8'($urandom));
    idle(1'b1, 3);
    n_checks++;
    if (obs24.size() !== 288) $display("FAIL b2b_count got %0d required 288", obs24.size());
    else n_pass++;
    for (int i = 0; i < obs24.size() && i < expq.size(); i++) begin
      if ({obs24[i].tl, obs24[i].tr, obs24[i].bl, obs24[i].br, obs24[i].col, obs24[i].row, obs24[i].done, obs24[i].cyc}
          !== {expq[i].tl, expq[i].tr, expq[i].bl, expq[i].br, expq[i].col, expq[i].row, expq[i].done, expq[i].cyc}) begin
        if (errs < 5)
          $display("FAIL b2b_win #%0d got %h,%h,%h,%h @(%0d,%0d) required %h,%h,%h,%h @(%0d,%0d)",
                   i, obs24[i].tl, obs24[i].tr, obs24[i].bl, obs24[i].br, obs24[i].col, obs24[i].row,
                   expq[i].tl, expq[i].tr, expq[i].bl, expq[i].br, expq[i].col, expq[i].row);
        errs++;
      end
      if ((int'(obs24[i].tl) + int'(obs24[i].tr) + int'(obs24[i].bl) + int'(obs24[i].br)) / 4 !== expq[i].avg)
        avg_errs++;
      if (obs24[i].done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL b2b_windows got %0d mismatching windows required 0", errs);
    else n_pass++;
    n_checks++;
    if (avg_errs !== 0) $display("FAIL b2b_pool_avg got %0d bad averages required 0", avg_errs);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 2) $display("FAIL b2b_frame_done got %0d required 2", done_cnt);
    else n_pass++;
  endtask

  task automatic test_max();
    int bad = 0;
    win_t lw;
    clear_queues();
    for (int p = 0; p < 576; p++) drive(1'b1, 1'b1, p == 0, 8'hFF);
    idle(1'b1, 3);
    n_checks++;
    if (obs24.size() !== 144) $display("FAIL max_count got %0d required 144", obs24.size());
    else n_pass++;
    foreach (obs24[i])
      if ({obs24[i].tl, obs24[i].tr, obs24[i].bl, obs24[i].br} !== 32'hFFFF_FFFF) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL max_values got %0d non-FF windows required 0", bad);
    else n_pass++;
    if (obs24.size() > 0) begin
      lw = obs24[obs24.size() - 1];
      n_checks++;
      if ({lw.col, lw.row, lw.done} !== {32'd11, 32'd11, 1'b1})
        $display("FAIL max_last got (%0d,%0d) done=%0d required (11,11) done=1", lw.col, lw.row, lw.done);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp(1'b0);
    test_ramp(1'b1);
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    test_max();
    n_checks++;
    if (stray_fd !== 0) $display("FAIL stray_frame_done got %0d required 0", stray_fd);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
